fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the instruction fetch stage, instruction
// memory and the downstream instruction register.
//
// Signals (direction as seen from the fetch unit, i.e. the master modport):
//   mem_req_o      out  read request to instruction memory
//   mem_addr_o     out  word-aligned fetch address, valid while mem_req_o=1
//   mem_ack_i      in   memory completion, mem_data_i valid in same cycle
//   mem_data_i     in   instruction word returned by memory
//   branch_en_i    in   redirect request (single-cycle pulse)
//   branch_addr_i  in   redirect target, bits [1:0] ignored
//   instr_o        out  fetched instruction
//   pc_o           out  address of instr_o
//   valid_o        out  instr_o/pc_o hold a valid, unconsumed entry
//   ready_i        in   downstream accepts the entry on valid_o & ready_i
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_data_i;
    logic            branch_en_i;
    logic [XLEN-1:0] branch_addr_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic            valid_o;
    logic            ready_i;

    // Fetch unit side
    modport master (
        output mem_req_o, mem_addr_o, instr_o, pc_o, valid_o,
        input  mem_ack_i, mem_data_i, branch_en_i, branch_addr_i, ready_i
    );

    // Environment side (memory, branch unit, instruction register)
    modport slave (
        input  mem_req_o, mem_addr_o, instr_o, pc_o, valid_o,
        output mem_ack_i, mem_data_i, branch_en_i, branch_addr_i, ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
//
// Owns the program counter, issues word reads to instruction memory over a
// req/ack handshake and presents each fetched instruction with its PC in a
// one-entry valid/ready output slot. A redirect may arrive at any time; any
// fetch that is in flight when it arrives is drained and its data dropped.
//
// Ports:
//   clk    in  system clock, all state updates on the rising edge
//   reset  in  synchronous, active-high reset
//   bus    fetch_unit_if.master (memory, redirect and output-slot signals)
//
// Parameters:
//   XLEN      data/address width
//   RESET_PC  PC loaded on reset, must be word aligned
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            req_active_q;
    logic [XLEN-1:0] req_addr_q;
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;

    logic            slot_free;
    logic            consumed;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_fire;
    logic [XLEN-1:0] branch_target;

    // Request generation. The slot-free test only gates the start of a
    // request: once req_active_q is set the request stays up with its
    // address frozen in req_addr_q until the memory acks it. In DRAIN the
    // request is always the stale one, so it is held unconditionally.
    always_comb begin
        slot_free     = !valid_q || bus.ready_i;
        consumed      = valid_q && bus.ready_i;
        mem_req       = (state_q == DRAIN) ||
                        ((state_q == FETCH) && (req_active_q || slot_free));
        mem_addr      = req_active_q ? req_addr_q : pc_q;
        mem_fire      = mem_req && bus.mem_ack_i;
        branch_target = bus.branch_addr_i & ALIGN_MASK;
    end

    assign bus.mem_req_o  = mem_req;
    assign bus.mem_addr_o = mem_addr;
    assign bus.instr_o    = instr_q;
    assign bus.pc_o       = pc_out_q;
    assign bus.valid_o    = valid_q;

    // Fetch FSM and output slot. A redirect always wins over an ack in the
    // same cycle and empties the slot even if it is being consumed. A request
    // that is on the bus without an ack at redirect time cannot be withdrawn,
    // so the FSM parks in DRAIN until that ack arrives and throws it away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_active_q <= 1'b0;
            req_addr_q   <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_out_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (bus.branch_en_i) begin
                        pc_q <= branch_target;
                    end
                end

                FETCH: begin
                    if (bus.branch_en_i) begin
                        pc_q    <= branch_target;
                        valid_q <= 1'b0;
                        if (mem_req && !bus.mem_ack_i) begin
                            state_q      <= DRAIN;
                            req_active_q <= 1'b1;
                            req_addr_q   <= mem_addr;
                        end else begin
                            req_active_q <= 1'b0;
                        end
                    end else if (mem_fire) begin
                        instr_q      <= bus.mem_data_i;
                        pc_out_q     <= pc_q;
                        valid_q      <= 1'b1;
                        pc_q         <= pc_q + PC_STEP;
                        req_active_q <= 1'b0;
                    end else begin
                        if (mem_req) begin
                            req_active_q <= 1'b1;
                            req_addr_q   <= mem_addr;
                        end
                        if (consumed) begin
                            valid_q <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    if (bus.branch_en_i) begin
                        pc_q    <= branch_target;
                        valid_q <= 1'b0;
                    end else if (consumed) begin
                        valid_q <= 1'b0;
                    end
                    // The stale request completes; leave DRAIN even if a new
                    // redirect arrived this cycle, since nothing is left in
                    // flight to wait for.
                    if (bus.mem_ack_i) begin
                        state_q      <= FETCH;
                        req_active_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Part 1 walks a table of per-cycle vectors through a default-reset DUT
// (zero-wait streaming, stall, ack latency, redirect with and without an
// in-flight request). Part 2 drives random traffic and compares against a
// transaction-level model. Part 3 uses a second DUT with RESET_PC near the
// top of the address space to cover PC wrap and reset mid-request.
module tb_fetch_unit;

    localparam int          XLEN = 32;
    localparam logic [31:0] KEY  = 32'hA5A5A5A5;
    localparam logic [31:0] HIGH_PC = 32'hFFFFFFF8;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) mif ();
    fetch_unit_if #(.XLEN(XLEN)) mif2 ();

    // Memory returns a word derived from the address so every instruction
    // identifies where it came from.
    assign mif.mem_data_i  = mif.mem_addr_o ^ KEY;
    assign mif2.mem_data_i = mif2.mem_addr_o ^ KEY;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h00000000)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (mif.master)
    );

    fetch_unit #(.XLEN(XLEN), .RESET_PC(HIGH_PC)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (mif2.master)
    );

    typedef struct {
        logic        ready;
        logic        branch;
        logic [31:0] baddr;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[20];

    // Reference model: tracks the next PC to fetch, the single in-flight
    // request (with a flag saying whether its data is to be thrown away)
    // and the contents of the output slot.
    logic        m_idle;
    logic [31:0] m_next_pc;
    logic        m_busy;
    logic [31:0] m_busy_addr;
    logic        m_discard;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    function automatic vec_t mkVec(input logic rdy, input logic br,
                                   input logic [31:0] baddr, input logic ack,
                                   input logic ereq, input logic [31:0] eaddr,
                                   input logic evalid, input logic [31:0] epc);
        vec_t v;
        v.ready = rdy; v.branch = br; v.baddr = baddr; v.ack = ack;
        v.exp_req = ereq; v.exp_addr = eaddr;
        v.exp_valid = evalid; v.exp_pc = epc;
        return v;
    endfunction

    task automatic applyStimulus(input logic rdy, input logic br,
                                 input logic [31:0] baddr, input logic ack);
        mif.ready_i       = rdy;
        mif.branch_en_i   = br;
        mif.branch_addr_i = baddr;
        mif.mem_ack_i     = ack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic modelComb(input logic rdy, output logic req,
                             output logic [31:0] addr);
        req  = !m_idle && (m_busy || !m_valid || rdy);
        addr = m_busy ? m_busy_addr : m_next_pc;
    endtask

    task automatic modelStep(input logic rst, input logic rdy, input logic br,
                             input logic [31:0] baddr, input logic ack);
        logic        req;
        logic [31:0] addr;
        logic        got;
        logic        still_busy;
        modelComb(rdy, req, addr);
        got = req && ack;
        if (rst) begin
            m_idle = 1'b1; m_next_pc = 32'h0; m_busy = 1'b0;
            m_busy_addr = 32'h0; m_discard = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            if (br) m_next_pc = baddr & ~32'd3;
        end else begin
            still_busy = req && !ack;
            if (br) begin
                m_valid   = 1'b0;
                m_next_pc = baddr & ~32'd3;
            end else if (got && !m_discard) begin
                m_valid   = 1'b1;
                m_instr   = addr ^ KEY;
                m_pc      = addr;
                m_next_pc = addr + 32'd4;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            m_discard   = still_busy && (m_discard || br);
            m_busy      = still_busy;
            m_busy_addr = addr;
        end
    endtask

    initial begin
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        r_rst, r_rdy, r_br, r_ack;
        logic [31:0] r_baddr;

        rst1 = 1'b1;
        rst2 = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        mif2.ready_i = 1'b1; mif2.branch_en_i = 1'b0;
        mif2.branch_addr_i = 32'h0; mif2.mem_ack_i = 1'b1;

        // ---------------- Part 1: table-driven vectors ----------------
        vecs[0]  = mkVec(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0);
        vecs[1]  = mkVec(1, 0, 32'h0,   1, 1, 32'h0,   1, 32'h0);
        vecs[2]  = mkVec(1, 0, 32'h0,   1, 1, 32'h4,   1, 32'h4);
        vecs[3]  = mkVec(1, 0, 32'h0,   1, 1, 32'h8,   1, 32'h8);
        for (int i = 4; i < 9; i++)
            vecs[i] = mkVec(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8);
        vecs[9]  = mkVec(1, 0, 32'h0,   1, 1, 32'hC,   1, 32'hC);
        vecs[10] = mkVec(1, 1, 32'h200, 1, 1, 32'h10,  0, 32'h0);
        vecs[11] = mkVec(1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0);
        vecs[12] = mkVec(1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0);
        vecs[13] = mkVec(1, 0, 32'h0,   1, 1, 32'h200, 1, 32'h200);
        vecs[14] = mkVec(1, 0, 32'h0,   0, 1, 32'h204, 0, 32'h0);
        vecs[15] = mkVec(1, 1, 32'h103, 0, 1, 32'h204, 0, 32'h0);
        vecs[16] = mkVec(1, 0, 32'h0,   0, 1, 32'h204, 0, 32'h0);
        vecs[17] = mkVec(1, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0);
        vecs[18] = mkVec(1, 0, 32'h0,   1, 1, 32'h100, 1, 32'h100);
        vecs[19] = mkVec(1, 0, 32'h0,   0, 1, 32'h104, 0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req",   32'(mif.mem_req_o), 32'h0);
        checkOutput("reset_addr",  mif.mem_addr_o,     32'h0);
        checkOutput("reset_valid", 32'(mif.valid_o),   32'h0);
        checkOutput("reset_pc",    mif.pc_o,           32'h0);
        checkOutput("reset_instr", mif.instr_o,        32'h0);
        checkOutput("reset2_addr", mif2.mem_addr_o,    HIGH_PC);

        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vecs[i].ready, vecs[i].branch, vecs[i].baddr, vecs[i].ack);
            #1;
            checkOutput($sformatf("vec%0d_req", i), 32'(mif.mem_req_o),
                        32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                checkOutput($sformatf("vec%0d_addr", i), mif.mem_addr_o,
                            vecs[i].exp_addr);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), 32'(mif.valid_o),
                        32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_pc", i), mif.pc_o, vecs[i].exp_pc);
                checkOutput($sformatf("vec%0d_instr", i), mif.instr_o,
                            vecs[i].exp_pc ^ KEY);
            end
        end

        // ---------------- Part 2: random traffic vs model ----------------
        @(negedge clk);
        rst1 = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        modelStep(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_rst   = ($urandom_range(0, 149) == 0);
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_br    = ($urandom_range(0, 11) == 0);
            r_ack   = ($urandom_range(0, 2) != 0);
            r_baddr = $urandom;
            rst1 = r_rst;
            applyStimulus(r_rdy, r_br, r_baddr, r_ack);
            #1;
            modelComb(r_rdy, exp_req, exp_addr);
            checkOutput("rand_req", 32'(mif.mem_req_o), 32'(exp_req));
            if (exp_req)
                checkOutput("rand_addr", mif.mem_addr_o, exp_addr);
            @(posedge clk);
            modelStep(r_rst, r_rdy, r_br, r_baddr, r_ack);
            #1;
            checkOutput("rand_valid", 32'(mif.valid_o), 32'(m_valid));
            if (m_valid) begin
                checkOutput("rand_pc",    mif.pc_o,    m_pc);
                checkOutput("rand_instr", mif.instr_o, m_instr);
            end
        end
        @(negedge clk);
        rst1 = 1'b0;

        // ---------------- Part 3: PC wrap and reset mid-request ----------------
        rst2 = 1'b0;
        #1;
        checkOutput("wrap_idle_req", 32'(mif2.mem_req_o), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("wrap%0d_req", k), 32'(mif2.mem_req_o), 32'h1);
            checkOutput($sformatf("wrap%0d_addr", k), mif2.mem_addr_o,
                        HIGH_PC + 32'(4 * k));
            @(posedge clk);
            #1;
            checkOutput($sformatf("wrap%0d_valid", k), 32'(mif2.valid_o), 32'h1);
            checkOutput($sformatf("wrap%0d_pc", k), mif2.pc_o, HIGH_PC + 32'(4 * k));
            checkOutput($sformatf("wrap%0d_instr", k), mif2.instr_o,
                        (HIGH_PC + 32'(4 * k)) ^ KEY);
        end
        @(negedge clk);
        mif2.mem_ack_i = 1'b0;
        #1;
        checkOutput("midreq_addr", mif2.mem_addr_o, 32'h4);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        checkOutput("midreq_held", 32'(mif2.mem_req_o), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("midreq_rst_req",   32'(mif2.mem_req_o), 32'h0);
        checkOutput("midreq_rst_valid", 32'(mif2.valid_o),   32'h0);
        @(negedge clk);
        rst2 = 1'b0;
        mif2.mem_ack_i = 1'b1;
        #1;
        checkOutput("post_rst_idle_req", 32'(mif2.mem_req_o), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("post_rst_req",  32'(mif2.mem_req_o), 32'h1);
        checkOutput("post_rst_addr", mif2.mem_addr_o,     HIGH_PC);
        @(posedge clk);
        #1;
        checkOutput("post_rst_pc",    mif2.pc_o,    HIGH_PC);
        checkOutput("post_rst_instr", mif2.instr_o, HIGH_PC ^ KEY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
